// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake, presents words downstream.
// Optional memory-response timeout guarded by FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned DATA_WIDTH = 31,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned PC_RESET   = 0,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH:0]   imem_rdata,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH:0]   instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {StFetch, StIssue, StHalt, StFault} state_e;

  localparam logic [ADDR_WIDTH-1:0] PcRaw   = ADDR_WIDTH'(PC_RESET);
  localparam logic [ADDR_WIDTH-1:0] PcReset = {PcRaw[ADDR_WIDTH-1:2], 2'b00};

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT must be in 1..255");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH:0]   instr_q, instr_d;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = StIssue;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
          // Current cycle is the TIMEOUT-th without ack; an ack here would have won above.
          if (cnt_q == 8'(TIMEOUT - 1)) state_d = StFault;
`endif
        end
      end
      StIssue: begin
        if (!stall) state_d = (instr_q[31:26] == 6'b111111) ? StHalt : StFetch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= PcReset;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    imem_req    = (state_q == StFetch);
    imem_addr   = pc_q;
    pc          = pc_q;
    instruction = instr_q;
    instr_valid = (state_q == StIssue);
    halted      = (state_q == StHalt);
    fault       = (state_q == StFault);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural model checked every cycle plus directed literal checks.
// A second instance with PC_RESET=0xFF exercises reset-PC masking and PC wrap.
module tb_fetch_unit;

  localparam int unsigned TO = 15;

  logic        clk, rst, stall, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, halted, fault;
  logic [7:0]  imem_addr, pc;
  logic [31:0] instruction;
  logic        w_req, w_valid, w_halted, w_fault;
  logic [7:0]  w_addr, w_pc;
  logic [31:0] w_instr;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.DATA_WIDTH(31), .ADDR_WIDTH(8), .PC_RESET(0), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .fault(fault)
  );

  fetch_unit #(.DATA_WIDTH(31), .ADDR_WIDTH(8), .PC_RESET(8'hFF), .TIMEOUT(TO)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(w_req), .imem_addr(w_addr), .instruction(w_instr),
    .instr_valid(w_valid), .pc(w_pc), .halted(w_halted), .fault(w_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the fetch stage is doing, in terms of words fetched and cycles waited.
  bit          m_known, m_issuing, m_halted, m_fault;
  logic [31:0] m_instr;
  int          m_nfetch, m_wait;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1; m_issuing = 0; m_halted = 0; m_fault = 0;
      m_instr = '0; m_nfetch = 0; m_wait = 0;
    end else if (m_halted || m_fault) begin
      // terminal until reset
    end else if (m_issuing) begin
      if (!stall) begin
        m_issuing = 0;
        if (m_instr[31:26] == 6'h3f) m_halted = 1;
      end
    end else if (imem_ack) begin
      m_instr = imem_rdata; m_nfetch++; m_wait = 0; m_issuing = 1;
    end else begin
      m_wait++;
`ifdef FETCH_TIMEOUT_EN
      if (m_wait == TO) m_fault = 1;
`endif
    end
    #1;
    if (m_known) begin
      check("m_req",    {31'd0, imem_req},    {31'd0, !m_issuing && !m_halted && !m_fault});
      check("m_valid",  {31'd0, instr_valid}, {31'd0, m_issuing});
      check("m_instr",  instruction,          m_instr);
      check("m_pc",     {24'd0, pc},          {24'd0, 8'(4 * m_nfetch)});
      check("m_addr",   {24'd0, imem_addr},   {24'd0, 8'(4 * m_nfetch)});
      check("m_halted", {31'd0, halted},      {31'd0, m_halted});
      check("m_fault",  {31'd0, fault},       {31'd0, m_fault});
      check("m_wpc",    {24'd0, w_pc},        {24'd0, 8'(252 + 4 * m_nfetch)});
    end
  end

  task automatic do_reset();
    rst = 1; stall = 0; imem_ack = 0;
    @(negedge clk);
    rst = 0;
  endtask

  // Ack one word on the first FETCH cycle, then stall its ISSUE for nstall cycles.
  task automatic fetch_word(input logic [31:0] data, input int nstall, input logic junk_ack);
    imem_ack = 1; imem_rdata = data; stall = 0;
    @(negedge clk);
    imem_ack = junk_ack; imem_rdata = 32'hDEADBEEF; stall = (nstall != 0);
    repeat (nstall) @(negedge clk);
    stall = 0; imem_ack = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; stall = 0; imem_ack = 0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", {24'd0, pc}, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'h1);
    check("rst_wpc", {24'd0, w_pc}, 32'hFC);
    rst = 0;

    // Back-to-back fetches at the minimum issue period.
    imem_ack = 1; imem_rdata = 32'h08431020;
    @(negedge clk);
    check("t1_valid", {31'd0, instr_valid}, 32'h1);
    check("t1_instr", instruction, 32'h08431020);
    check("t1_pc", {24'd0, pc}, 32'h4);
    imem_rdata = 32'h0C220004;
    @(negedge clk);
    check("t1_addr", {24'd0, imem_addr}, 32'h4);
    @(negedge clk);
    check("t1_instr2", instruction, 32'h0C220004);
    check("t1_pc2", {24'd0, pc}, 32'h8);
    imem_ack = 0;
    @(negedge clk);

    // Stall for 3 cycles with a stray ack during ISSUE.
    do_reset();
    fetch_word(32'h10220008, 3, 1'b1);
    check("t2_instr", instruction, 32'h10220008);
    check("t2_addr", {24'd0, imem_addr}, 32'h4);
    check("t2_req", {31'd0, imem_req}, 32'h1);

    // Halt opcode.
    do_reset();
    imem_ack = 1; imem_rdata = 32'hFC000000;
    @(negedge clk);
    check("t3_valid", {31'd0, instr_valid}, 32'h1);
    repeat (6) @(negedge clk);
    check("t3_halted", {31'd0, halted}, 32'h1);
    check("t3_req", {31'd0, imem_req}, 32'h0);
    check("t3_pc", {24'd0, pc}, 32'h4);
    do_reset();
    check("t3_rst_pc", {24'd0, pc}, 32'h0);
    check("t3_rst_halt", {31'd0, halted}, 32'h0);

    // PC wrap on the 0xFC-reset instance.
    fetch_word(32'h00000013, 0, 1'b0);
    check("t4_wrap", {24'd0, w_pc}, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    repeat (TO - 1) @(negedge clk);
    check("t5_nofault", {31'd0, fault}, 32'h0);
    @(negedge clk);
    check("t5_fault", {31'd0, fault}, 32'h1);
    do_reset();
    repeat (TO - 1) @(negedge clk);
    imem_ack = 1; imem_rdata = 32'h00000033;
    @(negedge clk);
    imem_ack = 0;
    check("t5_ack_wins", {31'd0, instr_valid}, 32'h1);
    check("t5_ack_nofault", {31'd0, fault}, 32'h0);
`else
    do_reset();
    repeat (40) @(negedge clk);
    check("t5_nofault", {31'd0, fault}, 32'h0);
    check("t5_waiting", {31'd0, imem_req}, 32'h1);
`endif

    // Reset collides with consume in ISSUE, then with ack in FETCH.
    do_reset();
    imem_ack = 1; imem_rdata = 32'h00000077;
    @(negedge clk);
    imem_ack = 0; stall = 0; rst = 1;
    @(negedge clk);
    check("t6_issue_instr", instruction, 32'h0);
    check("t6_issue_valid", {31'd0, instr_valid}, 32'h0);
    check("t6_issue_pc", {24'd0, pc}, 32'h0);
    rst = 1; imem_ack = 1; imem_rdata = 32'h12345678;
    @(negedge clk);
    check("t6_fetch_instr", instruction, 32'h0);
    check("t6_fetch_pc", {24'd0, pc}, 32'h0);
    check("t6_fetch_req", {31'd0, imem_req}, 32'h1);
    rst = 0; imem_ack = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and requests words from instruction memory through a req/ack handshake. Presents each fetched 32-bit instruction with a valid strobe and waits while the downstream stage stalls. Stops on a halt opcode, and optionally on a memory-response timeout.

## Interface
Parameters:
- DATA_WIDTH, default 31: MSB index of instruction words (word is [DATA_WIDTH:0]).
- ADDR_WIDTH, default 8: PC / memory byte-address width in bits.
- PC_RESET, default 0: PC value after reset; bits [1:0] ignored (forced 0).
- TIMEOUT, default 15: FETCH cycles without ack before fault (only with FETCH_TIMEOUT_EN); legal range 1..255.

Ports:
- clk: input, 1 bit. Single clock; all state changes on the rising edge.
- rst: input, 1 bit. Reset is synchronous and active-high.
- stall: input, 1 bit. Downstream cannot accept the presented instruction this cycle.
- imem_ack: input, 1 bit. Memory has placed imem_rdata for imem_addr.
- imem_rdata: input, [DATA_WIDTH:0]. Instruction word from memory, sampled only when imem_ack=1.
- imem_req: output, 1 bit. Fetch request.
- imem_addr: output, [ADDR_WIDTH-1:0]. Byte address; equals pc.
- instruction: output, [DATA_WIDTH:0]. Latched instruction to the decoder.
- instr_valid: output, 1 bit. The instruction output is new and must be consumed.
- pc: output, [ADDR_WIDTH-1:0]. Address of the next fetch.
- halted: output, 1 bit. A halt opcode was issued; fetching has stopped.
- fault: output, 1 bit. Timeout fault; fetching has stopped.

## Operation
- States: FETCH, ISSUE, HALT, FAULT. All outputs are Moore decodes of registered state or data registers. No combinational path from input to output.
- Reset values: state=FETCH, pc=PC_RESET with bits [1:0]=0, instruction=0, instr_valid=0, halted=0, fault=0, timeout counter=0. imem_req=1 from the first cycle after reset because state=FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - At an edge where imem_ack=1: instruction<=imem_rdata, pc<=pc+4 (mod 2^ADDR_WIDTH), counter<=0, go to ISSUE.
  - Otherwise: stay in FETCH and increment the counter.
- ISSUE:
  - imem_req=0, instr_valid=1. The instruction and pc registers are held.
  - At an edge where stall=0, the word is consumed. If instruction[31:26]==6'b111111, go to HALT; otherwise go to FETCH.
  - At an edge where stall=1: stay in ISSUE. instr_valid and instruction are unchanged.
- HALT: imem_req=0, instr_valid=0, halted=1. Exit only by rst. The halt word itself is issued to the decoder once.
- FAULT: imem_req=0, instr_valid=0, fault=1. Exit only by rst.
- imem_ack outside FETCH is ignored and has no effect on state.
- PC wrap: pc=2^ADDR_WIDTH-4 followed by an ack gives pc=0. No flag is raised.
- rst has priority over every transition in every state. An ack or halt in the same cycle as rst is discarded, and the next state is the reset state.

## Timing
- Minimum issue period is 2 cycles per instruction: ack in the first FETCH cycle, stall=0 in the ISSUE cycle.
- Fetch latency: instr_valid rises the cycle after the edge that sampled imem_ack=1.
- imem_addr is stable for the whole time imem_req=1. Memory may ack in any FETCH cycle, including the first.
- imem_req falls in the cycle after the accepting edge.
- Timeout edge case: if the ack arrives on the same edge that the counter reaches TIMEOUT, the ack wins and the state goes to ISSUE.

## Configuration
- Macro: FETCH_TIMEOUT_EN.
- Defined: the counter is present. After TIMEOUT consecutive FETCH cycles without ack, the next state is FAULT and fault=1.
- Undefined: no counter. FETCH waits indefinitely, FAULT is unreachable, and fault is constant 0.

## Test plan
- Reset then ack every FETCH cycle with words 0x08431020 and 0x0C220004 -> instr_valid on cycles 2 and 4, pc goes 0->4->8, imem_addr=0 then 4.
- Hold stall=1 for 3 cycles during ISSUE of 0x10220008 -> instr_valid stays high and instruction is unchanged for 4 cycles, no imem_req, and the next fetch is at pc=4.
- Fetch 0xFC000000 -> issued once with instr_valid=1, then halted=1 and imem_req=0 permanently. rst then returns pc to PC_RESET.
- With PC_RESET=0xFC and ADDR_WIDTH=8, one ack -> pc=0x00.
- With FETCH_TIMEOUT_EN, TIMEOUT=15, and no ack -> fault=1 after 15 FETCH cycles. Repeat with the ack on cycle 15 -> ISSUE, fault=0.
- Assert rst in ISSUE together with stall=0 and in FETCH together with imem_ack=1 -> next cycle shows reset values, instruction=0, and the acked word is dropped.
